sram_port_arbiter: RTL and testbench

- Shares one sram-like memory port between two requesters: the IF-stage instruction port (inst) and the EX/MEM data port (data).
- Sits between the CPU core and the sram-to-AXI bridge.
- Arbitrates address phases and locks a granted request until it is accepted.
- Records the owner of every accepted request in an in-order tag FIFO and routes each returned data_ok/rdata back to that owner.

---
 rtl/sram_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one sram-like memory port between the IF-stage instruction port
// (inst, owner 0) and the EX/MEM data port (data, owner 1). It sits between
// the CPU core and the sram-to-AXI bridge.
//
// Handshake semantics (applies to every port pair below):
//   A master raises *_sram_req with a stable payload and holds both until it
//   sees *_sram_addr_ok in the same cycle. The address phase completes on
//   mem_req & mem_addr_ok. Responses (mem_data_ok) arrive in acceptance order.
//   Each response is routed to its owner with zero latency via *_sram_data_ok.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_sram_* / data_sram_*   master-side request, payload, addr_ok, data_ok,
//                               rdata
//   mem_*                       shared slave-side port
//
// Parameters:
//   OST_DEPTH  maximum number of accepted-but-not-returned requests
//              (power of two, 2..16)
//   OST_PTR_W  log2(OST_DEPTH)
//
// Configuration macro:
//   SRAM_ARB_RR_EN  when defined, an unlocked grant with both masters
//                   requesting goes to the master that was not granted last.
//                   When undefined, fixed priority applies (data over inst).
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int OST_DEPTH = 4,
  parameter int OST_PTR_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction master
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data master
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // shared memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam logic [OST_PTR_W:0] DEPTH_CNT = (OST_PTR_W + 1)'(OST_DEPTH);

  // tag FIFO: one bit per outstanding request, holding its owner
  logic [OST_DEPTH-1:0] tag_mem;
  logic [OST_PTR_W-1:0] wr_ptr;
  logic [OST_PTR_W-1:0] rd_ptr;
  logic [OST_PTR_W:0]   count;

  // lock: remembers a granted-but-not-accepted owner so the grant cannot move
  logic lock_valid;
  logic lock_owner;

  logic grant;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head;

`ifdef SRAM_ARB_RR_EN
  logic rr_last;
`endif

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign head  = tag_mem[rd_ptr];

  // Grant selection. Defaults to data whenever data requests; when nobody
  // requests the value is irrelevant because mem_req is low.
  always_comb begin
    grant = data_sram_req;
    if (lock_valid) begin
      grant = lock_owner;
    end
`ifdef SRAM_ARB_RR_EN
    else if (inst_sram_req && data_sram_req) begin
      grant = ~rr_last;
    end
`endif
  end

  // Issue is blocked while full, even if a pop happens in the same cycle;
  // this keeps the full path free of the mem_data_ok input.
  assign mem_req = (inst_sram_req | data_sram_req | lock_valid) & ~full;
  assign push    = mem_req & mem_addr_ok;
  assign pop     = mem_data_ok & ~empty;

  // Payload mux, zeroed while no request is issued.
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'b00;
    mem_wstrb = 4'b0000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (mem_req) begin
      if (grant) begin
        mem_wr    = data_sram_wr;
        mem_size  = data_sram_size;
        mem_wstrb = data_sram_wstrb;
        mem_addr  = data_sram_addr;
        mem_wdata = data_sram_wdata;
      end else begin
        mem_wr    = inst_sram_wr;
        mem_size  = inst_sram_size;
        mem_wstrb = inst_sram_wstrb;
        mem_addr  = inst_sram_addr;
        mem_wdata = inst_sram_wdata;
      end
    end
  end

  assign inst_sram_addr_ok = push & ~grant;
  assign data_sram_addr_ok = push & grant;

  // A response with an empty FIFO is dropped: pop stays low, so neither
  // data_ok asserts and no state moves.
  assign inst_sram_data_ok = pop & ~head;
  assign data_sram_data_ok = pop & head;
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_mem    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= grant;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Lock on an issued-but-refused request; release on acceptance. While
      // full nothing is issued, so an existing lock is simply held.
      if (mem_req && !mem_addr_ok) begin
        lock_valid <= 1'b1;
        lock_owner <= grant;
      end else if (push) begin
        lock_valid <= 1'b0;
      end
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_last <= 1'b0;
    end else if (push) begin
      rr_last <= grant;
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Self-checking bench for sram_port_arbiter (OST_DEPTH = 4): directed vector
// table for idle, priority, lock, ordering, full and round-robin corners, a
// randomized run against a queue-based reference model, and a mid-run reset.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

  localparam int DEPTH = 4;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [31:0] IA = 32'h1c00_0000;
  localparam logic [31:0] DA = 32'h1c00_0100;
  localparam logic [31:0] DW = 32'hdead_beef;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  sram_port_arbiter #(.OST_DEPTH(DEPTH), .OST_PTR_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  // leaves time at posedge+1
  task automatic do_reset();
    drive_idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ireq, dreq, aok, dok;
    logic [31:0] rdata;
    logic        e_mreq;
    logic [31:0] e_addr;
    logic        e_wr, e_iaok, e_daok, e_idok, e_ddok;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic ireq, input logic dreq, input logic aok,
                              input logic dok, input logic [31:0] rdata,
                              input logic e_mreq, input logic [31:0] e_addr,
                              input logic e_wr, input logic e_iaok, input logic e_daok,
                              input logic e_idok, input logic e_ddok);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.e_mreq = e_mreq; v.e_addr = e_addr; v.e_wr = e_wr;
    v.e_iaok = e_iaok; v.e_daok = e_daok; v.e_idok = e_idok; v.e_ddok = e_ddok;
    vecs.push_back(v);
  endfunction

  function automatic void build_table();
    logic g2;
    g2 = ~RR; // owner of the 2nd grant when both masters keep requesting
    // idle
    repeat (5) add(0,0,0,0,0,        0,0,0,0,0,0,0);
    add(0,0,1,0,0,                   0,0,0,0,0,0,0);
    // priority: both request, data wins, inst follows
    add(1,1,1,0,0,                   1,DA,1,0,1,0,0);
    add(1,0,1,0,0,                   1,IA,0,1,0,0,0);
    add(0,0,0,1,32'h55,              0,0,0,0,0,0,1);
    add(0,0,0,1,32'h66,              0,0,0,0,0,1,0);
    // lock: inst refused, data arrives, grant stays on inst until accepted
    add(1,0,0,0,0,                   1,IA,0,0,0,0,0);
    add(1,1,0,0,0,                   1,IA,0,0,0,0,0);
    add(1,1,0,0,0,                   1,IA,0,0,0,0,0);
    add(1,1,1,0,0,                   1,IA,0,1,0,0,0);
    add(0,1,1,0,0,                   1,DA,1,0,1,0,0);
    // ordering: outstanding is inst, data, inst
    add(1,0,1,0,0,                   1,IA,0,1,0,0,0);
    add(0,0,0,1,32'h11,              0,0,0,0,0,1,0);
    add(0,0,0,1,32'h22,              0,0,0,0,0,0,1);
    add(0,0,0,1,32'h33,              0,0,0,0,0,1,0);
    // full
    repeat (4) add(1,0,1,0,0,        1,IA,0,1,0,0,0);
    add(1,0,1,0,0,                   0,0,0,0,0,0,0);
    add(1,0,1,1,32'h77,              0,0,0,0,0,1,0);
    add(1,0,0,0,0,                   1,IA,0,0,0,0,0);
    add(1,0,1,1,32'h88,              1,IA,0,1,0,1,0);
    repeat (3) add(0,0,0,1,32'h5a,   0,0,0,0,0,1,0);
    add(0,0,0,1,32'h99,              0,0,0,0,0,0,0);
    // both masters requesting continuously
    add(1,1,1,0,0,                   1,DA,1,0,1,0,0);
    add(1,1,1,1,32'ha1,              1,g2 ? DA : IA,g2,~g2,g2,0,1);
    add(1,1,1,1,32'ha2,              1,DA,1,0,1,~g2,g2);
    add(1,1,1,1,32'ha3,              1,g2 ? DA : IA,g2,~g2,g2,0,1);
    add(~RR,0,0,1,32'ha4,            ~RR,RR ? 32'h0 : IA,0,0,0,~g2,g2);
  endfunction

  // ---------------- reference model state ----------------
  bit          tag_q[$];       // owners of outstanding requests, oldest first
  logic [31:0] slv_q[$];       // slave's pending return values
  logic [31:0] exp_q[$];       // unused alias kept for symmetry
  logic [31:0] inst_exp_q[$];  // read data inst should see, in order
  logic [31:0] data_exp_q[$];
  int          lock_own;       // -1: no held grant
  bit          rr_last;

  bit          pi, pd;         // master has a pending request
  logic        iw, dw;
  logic [1:0]  isz, dsz;
  logic [3:0]  ist, dst;
  logic [31:0] ia, da, iwd, dwd;

  task automatic random_cycle();
    bit          full, any, g, emreq, acc, pop, eidok, eddok, aok, dok;
    logic [31:0] rd, v;
    if (!pi && $urandom_range(0, 1) == 1) begin
      pi = 1; iw = 1'($urandom_range(0, 1)); isz = 2'($urandom_range(0, 2));
      ist = 4'($urandom); ia = $urandom; iwd = $urandom;
    end
    if (!pd && $urandom_range(0, 1) == 1) begin
      pd = 1; dw = 1'($urandom_range(0, 1)); dsz = 2'($urandom_range(0, 2));
      dst = 4'($urandom); da = $urandom; dwd = $urandom;
    end
    aok = ($urandom_range(0, 3) != 0);
    if (slv_q.size() > 0) begin
      dok = ($urandom_range(0, 2) == 0);
      rd  = slv_q[0];
    end else begin
      dok = ($urandom_range(0, 15) == 0);
      rd  = $urandom;
    end
    inst_sram_req = pi; inst_sram_wr = iw; inst_sram_size = isz; inst_sram_wstrb = ist;
    inst_sram_addr = ia; inst_sram_wdata = iwd;
    data_sram_req = pd; data_sram_wr = dw; data_sram_size = dsz; data_sram_wstrb = dst;
    data_sram_addr = da; data_sram_wdata = dwd;
    mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;

    full  = (tag_q.size() == DEPTH);
    any   = pi || pd || (lock_own >= 0);
    if (lock_own >= 0)  g = lock_own[0];
    else if (pi && pd)  g = RR ? !rr_last : 1'b1;
    else                g = pd;
    emreq = any && !full;
    acc   = emreq && aok;
    pop   = dok && (tag_q.size() > 0);
    eidok = pop && (tag_q[0] == 1'b0);
    eddok = pop && (tag_q[0] == 1'b1);

    @(negedge clk);
    chk("mem_req", mem_req, emreq);
    chk("mem_wr", mem_wr, emreq ? (g ? dw : iw) : 1'b0);
    chk("mem_size", mem_size, emreq ? (g ? dsz : isz) : 2'b0);
    chk("mem_wstrb", mem_wstrb, emreq ? (g ? dst : ist) : 4'b0);
    chk("mem_addr", mem_addr, emreq ? (g ? da : ia) : 32'h0);
    chk("mem_wdata", mem_wdata, emreq ? (g ? dwd : iwd) : 32'h0);
    chk("inst_addr_ok", inst_sram_addr_ok, acc && !g);
    chk("data_addr_ok", data_sram_addr_ok, acc && g);
    chk("inst_data_ok", inst_sram_data_ok, eidok);
    chk("data_data_ok", data_sram_data_ok, eddok);
    chk("inst_rdata", inst_sram_rdata, rd);
    chk("data_rdata", data_sram_rdata, rd);
    if (eidok) begin
      if (inst_exp_q.size() == 0) chk("inst_sb_empty", 32'h1, 32'h0);
      else chk("inst_sb_rdata", inst_sram_rdata, inst_exp_q.pop_front());
    end
    if (eddok) begin
      if (data_exp_q.size() == 0) chk("data_sb_empty", 32'h1, 32'h0);
      else chk("data_sb_rdata", data_sram_rdata, data_exp_q.pop_front());
    end

    // advance the model to the next cycle
    if (pop) begin
      void'(tag_q.pop_front());
      void'(slv_q.pop_front());
    end
    if (acc) begin
      v = $urandom;
      tag_q.push_back(g);
      slv_q.push_back(v);
      if (g) data_exp_q.push_back(v); else inst_exp_q.push_back(v);
      lock_own = -1;
      rr_last  = g;
      if (g) pd = 0; else pi = 0;
    end else if (emreq) begin
      lock_own = int'(g);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive_idle();
    resetn = 1'b0;
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, 0);
    chk("rst_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 0);
    do_reset();

    build_table();
    foreach (vecs[i]) begin
      inst_sram_req = vecs[i].ireq; inst_sram_wr = 0; inst_sram_size = 2'd2;
      inst_sram_wstrb = 0; inst_sram_addr = IA; inst_sram_wdata = 0;
      data_sram_req = vecs[i].dreq; data_sram_wr = 1; data_sram_size = 2'd2;
      data_sram_wstrb = 4'hf; data_sram_addr = DA; data_sram_wdata = DW;
      mem_addr_ok = vecs[i].aok; mem_data_ok = vecs[i].dok; mem_rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", i), mem_req, vecs[i].e_mreq);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_mem_wr", i), mem_wr, vecs[i].e_wr);
      chk($sformatf("v%0d_inst_addr_ok", i), inst_sram_addr_ok, vecs[i].e_iaok);
      chk($sformatf("v%0d_data_addr_ok", i), data_sram_addr_ok, vecs[i].e_daok);
      chk($sformatf("v%0d_inst_data_ok", i), inst_sram_data_ok, vecs[i].e_idok);
      chk($sformatf("v%0d_data_data_ok", i), data_sram_data_ok, vecs[i].e_ddok);
      chk($sformatf("v%0d_rdata", i), inst_sram_rdata, vecs[i].rdata);
      @(posedge clk);
      #1;
    end

    // randomized run against the reference model
    do_reset();
    lock_own = -1; rr_last = 0; pi = 0; pd = 0;
    tag_q.delete(); slv_q.delete(); inst_exp_q.delete(); data_exp_q.delete();
    exp_q.delete();
    repeat (3000) random_cycle();

    // asynchronous reset with requests possibly outstanding
    drive_idle();
    resetn = 1'b0;
    #2;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h1234_5678;
    @(negedge clk);
    chk("postrst_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 0);
    chk("postrst_mem_req", mem_req, 0);
    @(posedge clk);
    #1 drive_idle();
    inst_sram_req = 1'b1; inst_sram_addr = IA; mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("postrst_issue", mem_req, 1);
    chk("postrst_inst_addr_ok", inst_sram_addr_ok, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
